// File: rtl/nes_pkg.sv
// Shared types and constants for the NES joypad reader: FSM states,
// button bit positions in the key byte and default pad timing.
package nes_pkg;

    localparam int unsigned DEF_CLK_HALF    = 300;
    localparam int unsigned DEF_POLL_PERIOD = 833333;

    localparam int unsigned KEY_W   = 8;
    localparam int unsigned BIT_IDX_W = $clog2(KEY_W);

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETTLE,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input; resets to the
// released (high) level so an idle pad reads as "nothing pressed".
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/joypad_reader.sv
// Polls two NES pads over a shared latch/clock pair and publishes the button bytes.
// Optional JOYPAD_DEBOUNCE_EN: a pad's keys only update when two consecutive reads agree.
module joypad_reader
    import nes_pkg::*;
#(
    parameter int unsigned CLK_HALF    = DEF_CLK_HALF,
    parameter int unsigned POLL_PERIOD = DEF_POLL_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll_req,
    input  logic       pad_data_p1,
    input  logic       pad_data_p2,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] keys_p1,
    output logic [7:0] keys_p2,
    output logic       keys_valid,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (POLL_PERIOD > 2 * CLK_HALF) ? POLL_PERIOD : 2 * CLK_HALF;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_HALF - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_HALF - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BTN_RIGHT);

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic                   pending;
    logic                   sample_c;
    logic [KEY_W-1:0]       shift_p1;
    logic [KEY_W-1:0]       shift_p2;
    logic                   data_p1_s;
    logic                   data_p2_s;

    sync_2ff u_sync_p1 (
        .clk   (clk),
        .reset (reset),
        .d     (pad_data_p1),
        .q     (data_p1_s)
    );

    sync_2ff u_sync_p2 (
        .clk   (clk),
        .reset (reset),
        .d     (pad_data_p2),
        .q     (data_p2_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and sample strobe; every phase ends when cnt hits its last value
    always_comb begin
        state_n  = state;
        sample_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (poll_req || pending || (cnt == IDLE_LAST)) begin
                    state_n = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (cnt == LATCH_LAST) begin
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == HALF_LAST) begin
                    sample_c = 1'b1;
                    state_n  = ST_CLK_LO;
                end
            end
            ST_CLK_LO: begin
                if (cnt == HALF_LAST) begin
                    state_n = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (cnt == HALF_LAST) begin
                    sample_c = 1'b1;
                    state_n  = (bit_idx == LAST_BIT) ? ST_DONE : ST_CLK_LO;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Phase counter, pending request, pad strobes and shift bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            pending   <= 1'b0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            busy      <= 1'b0;
            shift_p1  <= '0;
            shift_p2  <= '0;
        end else begin
            cnt       <= (state_n != state) ? '0 : cnt + 1'b1;
            pad_latch <= (state_n == ST_LATCH);
            pad_clk   <= (state_n != ST_CLK_LO);
            busy      <= (state_n != ST_IDLE);

            if (state == ST_IDLE) begin
                if (state_n == ST_LATCH) begin
                    pending <= 1'b0;
                end
            end else if (poll_req) begin
                pending <= 1'b1;
            end

            // bit_idx wraps 7 -> 0 after the last sample, ready for the next poll
            if (sample_c) begin
                shift_p1[bit_idx] <= ~data_p1_s;
                shift_p2[bit_idx] <= ~data_p2_s;
                bit_idx           <= bit_idx + 1'b1;
            end
        end
    end

`ifdef JOYPAD_DEBOUNCE_EN
    logic [KEY_W-1:0] raw_p1;
    logic [KEY_W-1:0] raw_p2;

    // Publish a pad only when this read matches the previous one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_p1     <= '0;
            raw_p2     <= '0;
            keys_p1    <= '0;
            keys_p2    <= '0;
            keys_valid <= 1'b0;
        end else begin
            keys_valid <= 1'b0;
            if (state == ST_DONE) begin
                raw_p1     <= shift_p1;
                raw_p2     <= shift_p2;
                keys_valid <= (shift_p1 == raw_p1) || (shift_p2 == raw_p2);
                if (shift_p1 == raw_p1) begin
                    keys_p1 <= shift_p1;
                end
                if (shift_p2 == raw_p2) begin
                    keys_p2 <= shift_p2;
                end
            end
        end
    end
`else
    // Publish both pads on every completed poll
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_p1    <= '0;
            keys_p2    <= '0;
            keys_valid <= 1'b0;
        end else begin
            keys_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                keys_p1 <= shift_p1;
                keys_p2 <= shift_p2;
            end
        end
    end
`endif

endmodule
